// File: rtl/pkg_divmod_ctrl.sv
// Shared types and helpers for the divide/modulo sequencing controller.
// Used by divmod_ctrl; the optional divide-by-zero trap is selected there
// with the DIVMOD_CTRL_DIV0_TRAP_EN macro.
package pkg_divmod_ctrl;

    // Cycles to wait for a divider to report before giving up.
    localparam int default_timeout_cycles = 80;

    // Controller sequencing states.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLaunch = 2'd1,
        StWait   = 2'd2,
        StResp   = 2'd3
    } State;

    // One request as presented by the core.
    typedef struct packed {
        logic        is_64;
        logic        sgn;
        logic [63:0] num;
        logic [63:0] denom;
    } StrcInDivmodReq;

    // One response as held for the core.
    typedef struct packed {
        logic [63:0] quot;
        logic [63:0] rem;
        logic        div0;
        logic        timeout;
    } StrcOutDivmodRsp;

    // A denominator is zero at the operation width; 32-bit requests ignore
    // the upper half.
    function automatic logic denom_is_zero(input logic is_64, input logic [63:0] denom);
        return is_64 ? (denom == 64'd0) : (denom[31:0] == 32'd0);
    endfunction

    // Trim a value to the operation width and zero-extend it to 64 bits.
    function automatic logic [63:0] op_width_value(input logic is_64, input logic [63:0] value);
        return is_64 ? value : {32'd0, value[31:0]};
    endfunction

endpackage

// File: rtl/divmod_ctrl.sv
// Sequencing controller in front of a 32-bit and a 64-bit divider.
// Accepts one request at a time, steers it to the divider matching its width,
// pulses that divider's enable once, waits (bounded) for its result and holds
// the response until the core takes it.
//
// Handshakes: a request transfers on a rising edge where req_valid and
// req_ready are both 1; a response transfers on a rising edge where rsp_valid
// and rsp_ready are both 1. req_ready and rsp_valid depend on state only, and
// rsp_* never change while rsp_valid=1 and rsp_ready=0.
//
// Build option: define DIVMOD_CTRL_DIV0_TRAP_EN to answer zero denominators
// locally (quotient all-ones, remainder = numerator, rsp_div0=1) without
// touching a divider. Without it, zero denominators go to the divider and
// rsp_div0 stays 0.
//
// dbg_state exposes the FSM state for checkers.
module divmod_ctrl
    import pkg_divmod_ctrl::*;
#(
    parameter int TIMEOUT_CYCLES = default_timeout_cycles
) (
    input  logic        clk,
    input  logic        rst_n,
    // Request port from the core
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_64,
    input  logic        req_sgn,
    input  logic [63:0] req_num,
    input  logic [63:0] req_denom,
    // Response port to the core
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_quot,
    output logic [63:0] rsp_rem,
    output logic        rsp_div0,
    output logic        rsp_timeout,
    // 32-bit divider
    output logic        d32_enable,
    output logic        d32_unsgn_or_sgn,
    output logic [31:0] d32_num,
    output logic [31:0] d32_denom,
    input  logic [31:0] d32_quot,
    input  logic [31:0] d32_rem,
    input  logic        d32_can_accept_cmd,
    input  logic        d32_data_ready,
    // 64-bit divider
    output logic        d64_enable,
    output logic        d64_unsgn_or_sgn,
    output logic [63:0] d64_num,
    output logic [63:0] d64_denom,
    input  logic [63:0] d64_quot,
    input  logic [63:0] d64_rem,
    input  logic        d64_can_accept_cmd,
    input  logic        d64_data_ready,
    // Debug
    output State        dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES);

    State             state;
    logic             lat_is_64;
    logic [CNT_W-1:0] cnt;
    StrcOutDivmodRsp  rsp_q;
    StrcInDivmodReq   req;

    logic             sel_can_accept;
    logic             sel_data_ready;
    logic [63:0]      sel_quot;
    logic [63:0]      sel_rem;
    logic             req_div0;

    assign req = {req_is_64, req_sgn, req_num, req_denom};

`ifdef DIVMOD_CTRL_DIV0_TRAP_EN
    assign req_div0 = denom_is_zero(req.is_64, req.denom);
`else
    assign req_div0 = 1'b0;
`endif

    // Route the status and results of the divider chosen by the latched width.
    always_comb begin
        sel_can_accept = d32_can_accept_cmd;
        sel_data_ready = d32_data_ready;
        sel_quot       = {32'd0, d32_quot};
        sel_rem        = {32'd0, d32_rem};
        if (lat_is_64) begin
            sel_can_accept = d64_can_accept_cmd;
            sel_data_ready = d64_data_ready;
            sel_quot       = d64_quot;
            sel_rem        = d64_rem;
        end
    end

    // Sequencing FSM with its registered divider commands and response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= StIdle;
            lat_is_64        <= 1'b0;
            cnt              <= '0;
            rsp_q            <= '0;
            d32_enable       <= 1'b0;
            d32_unsgn_or_sgn <= 1'b0;
            d32_num          <= 32'd0;
            d32_denom        <= 32'd0;
            d64_enable       <= 1'b0;
            d64_unsgn_or_sgn <= 1'b0;
            d64_num          <= 64'd0;
            d64_denom        <= 64'd0;
        end else begin
            // Enables are single-cycle pulses; they are only raised below.
            d32_enable <= 1'b0;
            d64_enable <= 1'b0;
            case (state)
                StIdle: begin
                    if (req_valid) begin
                        lat_is_64 <= req.is_64;
                        rsp_q     <= '0;
                        if (req_div0) begin
                            // Answered locally; no divider sees this request.
                            rsp_q.quot <= op_width_value(req.is_64, 64'hFFFF_FFFF_FFFF_FFFF);
                            rsp_q.rem  <= op_width_value(req.is_64, req.num);
                            rsp_q.div0 <= 1'b1;
                            state      <= StResp;
                        end else begin
                            // Only the selected divider's operands move; the
                            // other keeps whatever it last saw.
                            if (req.is_64) begin
                                d64_unsgn_or_sgn <= req.sgn;
                                d64_num          <= req.num;
                                d64_denom        <= req.denom;
                            end else begin
                                d32_unsgn_or_sgn <= req.sgn;
                                d32_num          <= req.num[31:0];
                                d32_denom        <= req.denom[31:0];
                            end
                            state <= StLaunch;
                        end
                    end
                end
                StLaunch: begin
                    if (sel_can_accept) begin
                        if (lat_is_64) begin
                            d64_enable <= 1'b1;
                        end else begin
                            d32_enable <= 1'b1;
                        end
                        cnt   <= '0;
                        state <= StWait;
                    end
                end
                StWait: begin
                    // At cnt=0 the divider may still show its previous result,
                    // so data_ready is only trusted from cnt=1 on. A result in
                    // the last cycle beats the timeout.
                    if ((cnt != '0) && sel_data_ready) begin
                        rsp_q.quot <= sel_quot;
                        rsp_q.rem  <= sel_rem;
                        state      <= StResp;
                    end else if (cnt == CNT_LAST) begin
                        rsp_q.quot    <= 64'd0;
                        rsp_q.rem     <= 64'd0;
                        rsp_q.timeout <= 1'b1;
                        state         <= StResp;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        state <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign req_ready   = (state == StIdle);
    assign rsp_valid   = (state == StResp);
    assign rsp_quot    = rsp_q.quot;
    assign rsp_rem     = rsp_q.rem;
    assign rsp_div0    = rsp_q.div0;
    assign rsp_timeout = rsp_q.timeout;
    assign dbg_state   = state;

    // At most one divider is enabled in any cycle.
    a_one_enable: assert property (@(posedge clk) disable iff (!rst_n)
        !(d32_enable && d64_enable));

    // An enable is only visible in the first wait cycle.
    a_enable_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
        (d32_enable || d64_enable) |-> (state == StWait && cnt == '0));

    // A pending response stays put until it is taken.
    a_rsp_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (state == StResp && !rsp_ready) |=> (state == StResp && $stable(rsp_q)));

endmodule

// File: tb/tb_divmod_ctrl.sv
// Directed bench for divmod_ctrl: a main instance with behavioural 32/64-bit
// dividers, and a short-timeout instance whose divider never finishes.
module tb_divmod_ctrl;
    import pkg_divmod_ctrl::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- main instance signals ----------------
    logic        req_valid, req_ready, req_is_64, req_sgn;
    logic [63:0] req_num, req_denom;
    logic        rsp_valid, rsp_ready, rsp_div0, rsp_timeout;
    logic [63:0] rsp_quot, rsp_rem;
    logic        d32_enable, d32_unsgn_or_sgn, d32_can_accept_cmd;
    logic [31:0] d32_num, d32_denom;
    logic [31:0] d32_quot = 32'hDEAD_BEEF;
    logic [31:0] d32_rem  = 32'hBAD0_BAD0;
    logic        d32_data_ready = 1'b1;
    logic        d64_enable, d64_unsgn_or_sgn, d64_can_accept_cmd;
    logic [63:0] d64_num, d64_denom;
    logic [63:0] d64_quot = 64'hDEAD_BEEF_DEAD_BEEF;
    logic [63:0] d64_rem  = 64'hBAD0_BAD0_BAD0_BAD0;
    logic        d64_data_ready = 1'b1;
    State        dbg_state;

    logic        cax32, cax64;
    assign d32_can_accept_cmd = cax32 & ~m32_busy;
    assign d64_can_accept_cmd = cax64 & ~m64_busy;

    // ---------------- short-timeout instance signals ----------------
    logic        t_req_valid, t_req_ready, t_req_is_64, t_req_sgn;
    logic [63:0] t_req_num, t_req_denom;
    logic        t_rsp_valid, t_rsp_ready, t_rsp_div0, t_rsp_timeout;
    logic [63:0] t_rsp_quot, t_rsp_rem;
    logic        t_d32_enable, t_d32_unsgn_or_sgn, t_d32_data_ready;
    logic [31:0] t_d32_num, t_d32_denom;
    logic        t_d64_enable, t_d64_unsgn_or_sgn;
    logic [63:0] t_d64_num, t_d64_denom;
    logic [31:0] t_d32_quot = 32'h0000_00AA;
    logic [31:0] t_d32_rem  = 32'h0000_0055;
    logic [63:0] t_d64_quot = 64'd0;
    logic [63:0] t_d64_rem  = 64'd0;
    logic        t_can_accept = 1'b1;
    logic        t_d64_data_ready = 1'b0;
    logic        t_dr = 1'b0;
    State        t_dbg_state;
    // Stale data_ready only while the enable is up (cnt=0), plus a forced pulse.
    assign t_d32_data_ready = t_d32_enable | t_dr;

    divmod_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_64(req_is_64),
        .req_sgn(req_sgn), .req_num(req_num), .req_denom(req_denom),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_quot(rsp_quot),
        .rsp_rem(rsp_rem), .rsp_div0(rsp_div0), .rsp_timeout(rsp_timeout),
        .d32_enable(d32_enable), .d32_unsgn_or_sgn(d32_unsgn_or_sgn),
        .d32_num(d32_num), .d32_denom(d32_denom), .d32_quot(d32_quot),
        .d32_rem(d32_rem), .d32_can_accept_cmd(d32_can_accept_cmd),
        .d32_data_ready(d32_data_ready),
        .d64_enable(d64_enable), .d64_unsgn_or_sgn(d64_unsgn_or_sgn),
        .d64_num(d64_num), .d64_denom(d64_denom), .d64_quot(d64_quot),
        .d64_rem(d64_rem), .d64_can_accept_cmd(d64_can_accept_cmd),
        .d64_data_ready(d64_data_ready),
        .dbg_state(dbg_state)
    );

    divmod_ctrl #(.TIMEOUT_CYCLES(10)) dut_to (
        .clk(clk), .rst_n(rst_n),
        .req_valid(t_req_valid), .req_ready(t_req_ready), .req_is_64(t_req_is_64),
        .req_sgn(t_req_sgn), .req_num(t_req_num), .req_denom(t_req_denom),
        .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready), .rsp_quot(t_rsp_quot),
        .rsp_rem(t_rsp_rem), .rsp_div0(t_rsp_div0), .rsp_timeout(t_rsp_timeout),
        .d32_enable(t_d32_enable), .d32_unsgn_or_sgn(t_d32_unsgn_or_sgn),
        .d32_num(t_d32_num), .d32_denom(t_d32_denom), .d32_quot(t_d32_quot),
        .d32_rem(t_d32_rem), .d32_can_accept_cmd(t_can_accept),
        .d32_data_ready(t_d32_data_ready),
        .d64_enable(t_d64_enable), .d64_unsgn_or_sgn(t_d64_unsgn_or_sgn),
        .d64_num(t_d64_num), .d64_denom(t_d64_denom), .d64_quot(t_d64_quot),
        .d64_rem(t_d64_rem), .d64_can_accept_cmd(t_can_accept),
        .d64_data_ready(t_d64_data_ready),
        .dbg_state(t_dbg_state)
    );

    // ---------------- behavioural dividers ----------------
    logic        m32_busy = 1'b0, m64_busy = 1'b0;
    int          m32_left, m64_left, m32_d, m64_d;
    logic [31:0] m32_pq, m32_pr;
    logic [63:0] m64_pq, m64_pr;

    // Take the operands on enable, drop the stale data_ready a cycle later,
    // report D cycles after the enable was seen.
    always @(negedge clk) begin
        if (!rst_n) begin
            m32_busy = 1'b0;
        end else if (d32_enable) begin
            m32_busy = 1'b1;
            m32_left = m32_d;
            if (d32_denom == 32'd0) begin
                m32_pq = 32'hFFFF_FFFF;
                m32_pr = d32_num;
            end else if (d32_unsgn_or_sgn) begin
                m32_pq = $signed(d32_num) / $signed(d32_denom);
                m32_pr = $signed(d32_num) % $signed(d32_denom);
            end else begin
                m32_pq = d32_num / d32_denom;
                m32_pr = d32_num % d32_denom;
            end
        end else if (m32_busy) begin
            d32_data_ready = 1'b0;
            m32_left--;
            if (m32_left == 0) begin
                m32_busy       = 1'b0;
                d32_data_ready = 1'b1;
                d32_quot       = m32_pq;
                d32_rem        = m32_pr;
            end
        end
    end

    // Same model at 64-bit width.
    always @(negedge clk) begin
        if (!rst_n) begin
            m64_busy = 1'b0;
        end else if (d64_enable) begin
            m64_busy = 1'b1;
            m64_left = m64_d;
            if (d64_denom == 64'd0) begin
                m64_pq = 64'hFFFF_FFFF_FFFF_FFFF;
                m64_pr = d64_num;
            end else if (d64_unsgn_or_sgn) begin
                m64_pq = $signed(d64_num) / $signed(d64_denom);
                m64_pr = $signed(d64_num) % $signed(d64_denom);
            end else begin
                m64_pq = d64_num / d64_denom;
                m64_pr = d64_num % d64_denom;
            end
        end else if (m64_busy) begin
            d64_data_ready = 1'b0;
            m64_left--;
            if (m64_left == 0) begin
                m64_busy       = 1'b0;
                d64_data_ready = 1'b1;
                d64_quot       = m64_pq;
                d64_rem        = m64_pr;
            end
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%h expected=0x%h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Issue one request on the main instance (starting near a falling edge),
    // follow it to the response and check everything along the way.
    task automatic run_op(input string tag, input logic is64, input logic sgn,
                          input logic [63:0] num, input logic [63:0] denom,
                          input int cax_hold, input int rsp_hold,
                          input logic [63:0] exp_q, input logic [63:0] exp_r,
                          input logic exp_div0, input logic exp_to,
                          input int exp_en, input int exp_rsp_n,
                          input int exp_c32, input int exp_c64);
        int n, en_delay, c32, c64;
        check_eq({tag, "_idle_ready"}, 64'(req_ready), 64'd1);
        req_is_64 = is64; req_sgn = sgn; req_num = num; req_denom = denom;
        cax32 = (cax_hold == 0); cax64 = (cax_hold == 0);
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 1; en_delay = -1; c32 = 0; c64 = 0;
        while (!rsp_valid && n < 300) begin
            if (d32_enable) c32++;
            if (d64_enable) c64++;
            if ((is64 ? d64_enable : d32_enable) && en_delay < 0) begin
                en_delay = n;
                if (is64) begin
                    check_eq({tag, "_op_num"},   d64_num, num);
                    check_eq({tag, "_op_denom"}, d64_denom, denom);
                    check_eq({tag, "_op_sgn"},   64'(d64_unsgn_or_sgn), 64'(sgn));
                end else begin
                    check_eq({tag, "_op_num"},   64'(d32_num), {32'd0, num[31:0]});
                    check_eq({tag, "_op_denom"}, 64'(d32_denom), {32'd0, denom[31:0]});
                    check_eq({tag, "_op_sgn"},   64'(d32_unsgn_or_sgn), 64'(sgn));
                end
            end
            if (n == cax_hold + 1) begin
                cax32 = 1'b1; cax64 = 1'b1;
            end
            @(negedge clk);
            n++;
        end
        cax32 = 1'b1; cax64 = 1'b1;
        check_eq({tag, "_rsp_arrived"}, 64'(rsp_valid), 64'd1);
        check_eq({tag, "_rsp_cycle"},   64'(n), 64'(exp_rsp_n));
        check_eq({tag, "_en_cycle"},    64'(en_delay), 64'(exp_en));
        check_eq({tag, "_en32_count"},  64'(c32), 64'(exp_c32));
        check_eq({tag, "_en64_count"},  64'(c64), 64'(exp_c64));
        for (int i = 0; i <= rsp_hold; i++) begin
            check_eq({tag, "_quot"},      rsp_quot, exp_q);
            check_eq({tag, "_rem"},       rsp_rem, exp_r);
            check_eq({tag, "_div0"},      64'(rsp_div0), 64'(exp_div0));
            check_eq({tag, "_timeout"},   64'(rsp_timeout), 64'(exp_to));
            check_eq({tag, "_hold_valid"}, 64'(rsp_valid), 64'd1);
            check_eq({tag, "_hold_busy"},  64'(req_ready), 64'd0);
            if (i < rsp_hold) @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq({tag, "_done_valid"}, 64'(rsp_valid), 64'd0);
        check_eq({tag, "_done_ready"}, 64'(req_ready), 64'd1);
    endtask

    // One request on the short-timeout instance. With tie=1 data_ready is
    // forced in the very cycle the counter reaches the limit.
    task automatic run_timeout(input string tag, input logic tie);
        int n;
        t_req_is_64 = 1'b0; t_req_sgn = 1'b0; t_req_num = 64'd5; t_req_denom = 64'd1;
        t_req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t_req_valid = 1'b0;
        n = 0;
        while (!t_d32_enable && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_enable_seen"}, 64'(t_d32_enable), 64'd1);
        n = 0;
        while (!t_rsp_valid && n < 50) begin
            if (tie && n == 10) t_dr = 1'b1;
            @(negedge clk);
            n++;
        end
        t_dr = 1'b0;
        check_eq({tag, "_rsp_cycle"}, 64'(n), 64'd11);
        check_eq({tag, "_timeout"},   64'(t_rsp_timeout), tie ? 64'd0 : 64'd1);
        check_eq({tag, "_quot"},      t_rsp_quot, tie ? 64'h0000_0000_0000_00AA : 64'd0);
        check_eq({tag, "_rem"},       t_rsp_rem, tie ? 64'h0000_0000_0000_0055 : 64'd0);
        check_eq({tag, "_div0"},      64'(t_rsp_div0), 64'd0);
        t_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t_rsp_ready = 1'b0;
        check_eq({tag, "_back_idle"}, 64'(t_req_ready), 64'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        rst_n = 1'b0;
        req_valid = 1'b0; req_is_64 = 1'b0; req_sgn = 1'b0;
        req_num = 64'd0; req_denom = 64'd0; rsp_ready = 1'b0;
        cax32 = 1'b1; cax64 = 1'b1;
        t_req_valid = 1'b0; t_req_is_64 = 1'b0; t_req_sgn = 1'b0;
        t_req_num = 64'd0; t_req_denom = 64'd0; t_rsp_ready = 1'b0;
        m32_d = 33; m64_d = 5;
        repeat (3) @(negedge clk);

        // Reset values
        check_eq("rst_req_ready",   64'(req_ready), 64'd1);
        check_eq("rst_state",       64'(dbg_state), 64'(StIdle));
        check_eq("rst_rsp_valid",   64'(rsp_valid), 64'd0);
        check_eq("rst_rsp_quot",    rsp_quot, 64'd0);
        check_eq("rst_rsp_rem",     rsp_rem, 64'd0);
        check_eq("rst_rsp_flags",   {62'd0, rsp_div0, rsp_timeout}, 64'd0);
        check_eq("rst_d32_cmd",     {d32_enable, d32_unsgn_or_sgn, d32_num, d32_denom[29:0]}, 64'd0);
        check_eq("rst_d64_cmd",     {62'd0, d64_enable, d64_unsgn_or_sgn}, 64'd0);
        check_eq("rst_d64_num",     d64_num | d64_denom, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 32-bit unsigned 100/7, stale data_ready at cnt=0 must be ignored
        run_op("u32", 1'b0, 1'b0, 64'd100, 64'd7, 0, 0,
               64'd14, 64'd2, 1'b0, 1'b0, 2, 36, 1, 0);

        // 64-bit signed -100/7
        run_op("s64", 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 0, 0,
               64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 2, 8, 0, 1);

        // 32-bit signed: result zero-extended, upper operand bits ignored
        m32_d = 2;
        run_op("s32", 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'h1234_0000_0000_0007, 0, 0,
               64'h0000_0000_FFFF_FFF2, 64'h0000_0000_FFFF_FFFE, 1'b0, 1'b0, 2, 5, 1, 0);

        // Zero denominators
        m32_d = 3; m64_d = 5;
`ifdef DIVMOD_CTRL_DIV0_TRAP_EN
        run_op("div0_32", 1'b0, 1'b0, 64'h1234, 64'h0, 0, 0,
               64'h0000_0000_FFFF_FFFF, 64'h1234, 1'b1, 1'b0, -1, 1, 0, 0);
        run_op("div0_32hi", 1'b0, 1'b0, 64'hABCD_0000_0000_0009, 64'h1_0000_0000, 0, 0,
               64'h0000_0000_FFFF_FFFF, 64'h9, 1'b1, 1'b0, -1, 1, 0, 0);
        run_op("div0_64", 1'b1, 1'b0, 64'h1_0000_0005, 64'h0, 0, 0,
               64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0005, 1'b1, 1'b0, -1, 1, 0, 0);
`else
        run_op("div0_32", 1'b0, 1'b0, 64'h1234, 64'h0, 0, 0,
               64'h0000_0000_FFFF_FFFF, 64'h1234, 1'b0, 1'b0, 2, 6, 1, 0);
        run_op("div0_32hi", 1'b0, 1'b0, 64'hABCD_0000_0000_0009, 64'h1_0000_0000, 0, 0,
               64'h0000_0000_FFFF_FFFF, 64'h9, 1'b0, 1'b0, 2, 6, 1, 0);
        run_op("div0_64", 1'b1, 1'b0, 64'h1_0000_0005, 64'h0, 0, 0,
               64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0005, 1'b0, 1'b0, 2, 8, 0, 1);
`endif

        // Back-pressure on both sides: launch delayed 3 cycles, response held 5
        m32_d = 4;
        run_op("bp", 1'b0, 1'b0, 64'd1000, 64'd10, 3, 5,
               64'd100, 64'd0, 1'b0, 1'b0, 5, 10, 1, 0);

        // Reset while waiting on the divider
        m32_d = 40;
        req_is_64 = 1'b0; req_sgn = 1'b0; req_num = 64'd77; req_denom = 64'd5;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (!d32_enable && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_eq("rstmid_enable_seen", 64'(d32_enable), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rstmid_enable",    64'(d32_enable), 64'd0);
        check_eq("rstmid_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("rstmid_req_ready", 64'(req_ready), 64'd1);
        check_eq("rstmid_d32_num",   64'(d32_num), 64'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        m32_d = 3;
        run_op("after_rst", 1'b0, 1'b0, 64'd20, 64'd3, 0, 0,
               64'd6, 64'd2, 1'b0, 1'b0, 2, 6, 1, 0);

        // Hung divider, then a result exactly at the limit
        run_timeout("timeout", 1'b0);
        run_timeout("tie", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound in case something upstream stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule
